// File: rtl/fir_decim_out.sv
// FIR output stage: keeps every Mth sample, rounds and scales it, saturates it to OUT_WIDTH,
// then queues it in a small FIFO toward a ready/valid consumer.
module fir_decim_out #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned SHIFT     = 4,
  parameter int unsigned M         = 4,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           y_in,
  input  logic                       in_valid,
  input  logic                       flush,
  input  logic                       clr_flags,
  output logic [OUT_WIDTH-1:0]       d_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       sat_flag,
  output logic                       drop_flag
);

  localparam int unsigned PW = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(M - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
  localparam logic signed [WIDTH:0] RND     = ((WIDTH+1)'(1) << SHIFT) >> 1;
  localparam logic signed [WIDTH:0] SAT_MAX = {{(WIDTH+2-OUT_WIDTH){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH:0] SAT_MIN = {{(WIDTH+2-OUT_WIDTH){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic [PW-1:0]        phase;
  logic                 stage_valid;
  logic [OUT_WIDTH-1:0] stage_data;
  logic [OUT_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;

  logic signed [WIDTH:0] ext, sum, r;
  logic [OUT_WIDTH-1:0]  res_c;
  logic                  sat_c;
  logic                  keep, pop, push, drop_ev;
  logic [AW-1:0]         rd_nxt;
  logic [LW-1:0]         level_nxt;
  logic [OUT_WIDTH-1:0]  head_nxt;

  // Round half-up in WIDTH+1 bits so the rounding add can never wrap.
  assign ext = {y_in[WIDTH-1], y_in};
  assign sum = ext + RND;
  assign r   = sum >>> SHIFT;

  always_comb begin
    res_c = r[OUT_WIDTH-1:0];
    sat_c = 1'b0;
    if (r > SAT_MAX) begin
      res_c = SAT_MAX[OUT_WIDTH-1:0];
      sat_c = 1'b1;
    end else if (r < SAT_MIN) begin
      res_c = SAT_MIN[OUT_WIDTH-1:0];
      sat_c = 1'b1;
    end
  end

  // Control for the handshake and the FIFO. A push into a full FIFO still succeeds when a pop
  // frees a slot on the same edge.
  always_comb begin
    keep      = in_valid && (phase == PHASE_LAST);
    pop       = out_valid && out_ready;
    push      = stage_valid && ((level != LEVEL_FULL) || pop);
    drop_ev   = stage_valid && !push;
    rd_nxt    = pop ? rd_ptr + AW'(1) : rd_ptr;
    level_nxt = level + LW'(push) - LW'(pop);
    head_nxt  = (push && (wr_ptr == rd_nxt)) ? stage_data : mem[rd_nxt];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase       <= '0;
      stage_valid <= 1'b0;
      stage_data  <= '0;
    end else if (flush) begin
      phase       <= '0;
      stage_valid <= 1'b0;
    end else begin
      if (in_valid) phase <= (phase == PHASE_LAST) ? '0 : phase + PW'(1);
      stage_valid <= keep;
      if (keep) stage_data <= res_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (!flush && push) begin
      mem[wr_ptr] <= stage_data;
    end
  end

  // d_out is a registered copy of the head entry, so it stays stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      d_out     <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr    <= rd_nxt;
      level     <= level_nxt;
      out_valid <= (level_nxt != '0);
      d_out     <= head_nxt;
    end
  end

  // Sticky flags. A new event in the same cycle as clr_flags keeps its flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_flag  <= 1'b0;
      drop_flag <= 1'b0;
    end else begin
      sat_flag  <= (sat_flag && !clr_flags) || (keep && sat_c && !flush);
      drop_flag <= (drop_flag && !clr_flags) || (drop_ev && !flush);
    end
  end

endmodule

// File: tb/tb_fir_decim_out.sv
// Directed bench for fir_decim_out. A queue holds the expected outputs, and each handshake is
// checked against the head of that queue.
module tb_fir_decim_out;

  localparam int unsigned WIDTH = 32, OUT_W = 16, SHIFT = 4, M = 4, DEPTH = 4;

  logic              clk, rst, in_valid, flush, clr_flags, out_ready;
  logic [WIDTH-1:0]  y_in;
  logic [OUT_W-1:0]  d_out;
  logic              out_valid, sat_flag, drop_flag;
  logic [2:0]        level;

  int               asserts = 0;
  int               fails   = 0;
  int               phase_m = 0;
  logic [OUT_W-1:0] q[$];

  fir_decim_out #(.WIDTH(WIDTH), .OUT_WIDTH(OUT_W), .SHIFT(SHIFT), .M(M), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .y_in(y_in), .in_valid(in_valid), .flush(flush),
    .clr_flags(clr_flags), .d_out(d_out), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .sat_flag(sat_flag), .drop_flag(drop_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [OUT_W-1:0] model(input int y);
    longint v;
    v = longint'(y);
    if (SHIFT > 0) v = v + (longint'(1) <<< (SHIFT - 1));
    v = v >>> SHIFT;
    if (v > (longint'(1) <<< (OUT_W - 1)) - 1) v = (longint'(1) <<< (OUT_W - 1)) - 1;
    else if (v < -(longint'(1) <<< (OUT_W - 1))) v = -(longint'(1) <<< (OUT_W - 1));
    return v[OUT_W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check any handshake that completes at the coming edge, then advance one cycle.
  task automatic tick();
    if (out_valid === 1'b1 && out_ready) begin
      asserts++;
      assert (q.size() > 0) else begin
        fails++;
        $error("FAIL unexpected_out: observed %0h expected no output", d_out);
      end
      if (q.size() > 0) chk("dout", 32'(d_out), 32'(q.pop_front()));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int y, input bit ok);
    in_valid = 1'b1;
    y_in = y;
    if (phase_m == M - 1 && ok) q.push_back(model(y));
    tick();
    phase_m = (phase_m == M - 1) ? 0 : phase_m + 1;
    in_valid = 1'b0;
  endtask

  task automatic send_kept(input int y, input bit ok);
    while (phase_m != M - 1) feed(0, 1'b1);
    feed(y, ok);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0) break;
      tick();
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
    chk("drain_level", 32'(level), 32'd0);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; clr_flags = 1'b0; out_ready = 1'b1; y_in = '0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_d_out", 32'(d_out), 32'd0);
    chk("rst_sat", 32'(sat_flag), 32'd0);
    chk("rst_drop", 32'(drop_flag), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Decimated ramp with out_ready held high.
    for (int i = 1; i <= 8; i++) begin
      feed(16 * i, 1'b1);
      chk("ramp_lvl_le1", 32'(level <= 3'd1), 32'd1);
      if (i == 4) chk("ramp_stage_only", 32'(out_valid), 32'd0);
      if (i == 5) begin
        chk("ramp_latency_valid", 32'(out_valid), 32'd1);
        chk("ramp_latency_data", 32'(d_out), 32'd4);
      end
    end
    drain();

    // Rounding, half-up toward +inf.
    send_kept(24, 1'b1);
    send_kept(-24, 1'b1);
    send_kept(-25, 1'b1);
    drain();
    chk("round_no_sat", 32'(sat_flag), 32'd0);

    // Saturation on both rails, then clearing the sticky flag.
    send_kept(32'h7FFF_FFFF, 1'b1);
    send_kept(32'h8000_0000, 1'b1);
    drain();
    chk("sat_set", 32'(sat_flag), 32'd1);
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    chk("sat_clr", 32'(sat_flag), 32'd0);
    clr_flags = 1'b1;
    send_kept(32'h7FFF_FFFF, 1'b1);
    clr_flags = 1'b0;
    chk("sat_wins_clr", 32'(sat_flag), 32'd1);
    drain();

    // Backpressure: six kept samples, the last two overflow.
    chk("bp_drop_pre", 32'(drop_flag), 32'd0);
    out_ready = 1'b0;
    for (int n = 1; n <= 6; n++) send_kept(16 * n, n <= 4);
    tick(); tick();
    chk("bp_level", 32'(level), 32'd4);
    chk("bp_drop", 32'(drop_flag), 32'd1);
    chk("bp_head", 32'(d_out), 32'd1);
    drain();

    // Full FIFO with a stage push and a pop on the same edge.
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    chk("fp_flags_clr", 32'({sat_flag, drop_flag}), 32'd0);
    out_ready = 1'b0;
    for (int n = 10; n <= 13; n++) send_kept(16 * n, 1'b1);
    send_kept(16 * 14, 1'b1);
    chk("fp_level_full", 32'(level), 32'd4);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("fp_level_stays", 32'(level), 32'd4);
    chk("fp_no_drop", 32'(drop_flag), 32'd0);
    drain();

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    send_kept(16, 1'b1); send_kept(32, 1'b1); send_kept(48, 1'b1);
    tick();
    chk("mr_level3", 32'(level), 32'd3);
    rst = 1'b0;
    #1;
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_level", 32'(level), 32'd0);
    chk("mr_d_out", 32'(d_out), 32'd0);
    rst = 1'b1;
    q.delete();
    phase_m = 0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    feed(160, 1'b1); feed(160, 1'b1); feed(160, 1'b1); feed(48, 1'b1);
    drain();

    // Synchronous flush with in_valid high; flags survive.
    out_ready = 1'b0;
    send_kept(32'h7FFF_FFFF, 1'b1); send_kept(16, 1'b1); send_kept(32, 1'b1);
    tick();
    chk("fl_level3", 32'(level), 32'd3);
    flush = 1'b1; in_valid = 1'b1; y_in = 64;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_level", 32'(level), 32'd0);
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_sat_kept", 32'(sat_flag), 32'd1);
    chk("fl_drop_kept", 32'(drop_flag), 32'd0);
    q.delete();
    phase_m = 0;
    out_ready = 1'b1;
    send_kept(32, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
